// File: rtl/ray_column_scheduler.sv
// ---------------------------------------------------------------------------
// ray_column_scheduler
//
// Frame-level sequencer for the raycaster. For every screen column it derives
// the ray angle, fires the horizontal and vertical wall finders together,
// waits for both (or for a timeout), keeps the nearer hit and offers one
// result per column to the renderer over a valid/ready handshake.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_frame_i             begin a frame (ignored while busy)
//   player_x_i/player_y_i     player position, latched at frame start
//   player_ang_x_i/_y_i       heading (int degrees / 1/1024 degree fraction)
//   alpha_x_o/alpha_y_o       current ray angle to both finders
//   begin_calc_o              one-cycle launch pulse to both finders
//   end_calc_h_i/_v_i         finder done levels
//   found_h_i/_v_i            finder wall-found flags
//   wall_{x,y}_{h,v}_i        finder hit coordinates
//   col_valid_o/col_ready_i   result handshake
//   col_index_o, col_hit_o, col_side_o, col_wall_x_o, col_wall_y_o,
//   col_dist2_o               per-column result
//   busy_o                    frame in progress
//   frame_done_o              one-cycle pulse after the last column is taken
// ---------------------------------------------------------------------------
module ray_column_scheduler #(
  parameter int NUM_COLS   = 320,
  parameter int FOV_DEG    = 60,
  parameter int ANGLE_STEP = 192,
  parameter int TIMEOUT    = 4096
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_frame_i,
  input  logic signed [12:0] player_x_i,
  input  logic signed [12:0] player_y_i,
  input  logic [9:0]         player_ang_x_i,
  input  logic [9:0]         player_ang_y_i,
  output logic [9:0]         alpha_x_o,
  output logic [9:0]         alpha_y_o,
  output logic               begin_calc_o,
  input  logic               end_calc_h_i,
  input  logic               end_calc_v_i,
  input  logic               found_h_i,
  input  logic               found_v_i,
  input  logic signed [12:0] wall_x_h_i,
  input  logic signed [12:0] wall_y_h_i,
  input  logic signed [12:0] wall_x_v_i,
  input  logic signed [12:0] wall_y_v_i,
  output logic               col_valid_o,
  input  logic               col_ready_i,
  output logic [8:0]         col_index_o,
  output logic               col_hit_o,
  output logic               col_side_o,
  output logic signed [12:0] col_wall_x_o,
  output logic signed [12:0] col_wall_y_o,
  output logic [26:0]        col_dist2_o,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam logic [19:0]        ANG_MOD    = 20'd368640;
  localparam logic [19:0]        HALF_FOV   = 20'(FOV_DEG * 512);
  localparam logic [19:0]        ANG_STEP   = 20'(ANGLE_STEP);
  localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [8:0]         COL_LAST   = 9'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_SELECT = 3'd3,
    S_OUTPUT = 3'd4,
    S_NEXT   = 3'd5
  } state_e;

  // Squared distance on sign-extended 14-bit differences. Each square is
  // below 2^26, so the sum always fits the 27-bit result.
  function automatic logic [26:0] dist2(input logic signed [12:0] wx,
                                        input logic signed [12:0] wy,
                                        input logic signed [12:0] px,
                                        input logic signed [12:0] py);
    logic signed [13:0] dx;
    logic signed [13:0] dy;
    logic signed [27:0] sx;
    logic signed [27:0] sy;
    dx = {wx[12], wx} - {px[12], px};
    dy = {wy[12], wy} - {py[12], py};
    sx = dx * dx;
    sy = dy * dy;
    return 27'(sx) + 27'(sy);
  endfunction

  state_e              state_q, state_d;
  logic [8:0]          col_q, col_d;
  logic [18:0]         acc_q, acc_d;
  logic signed [12:0]  px_q, px_d, py_q, py_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                first_q, first_d;
  logic                done_h_q, done_h_d, done_v_q, done_v_d;
  logic                found_h_q, found_h_d, found_v_q, found_v_d;
  logic signed [12:0]  wx_h_q, wx_h_d, wy_h_q, wy_h_d;
  logic signed [12:0]  wx_v_q, wx_v_d, wy_v_q, wy_v_d;
  logic                hit_q, hit_d, side_q, side_d;
  logic signed [12:0]  cwx_q, cwx_d, cwy_q, cwy_d;
  logic [26:0]         cd2_q, cd2_d;
  logic                frame_done_q, frame_done_d;
  logic                begin_calc_q, col_valid_q, busy_q;

  logic [19:0]         heading_s, start_diff_s, step_sum_s;
  logic [18:0]         start_acc_s, next_acc_s;
  logic [26:0]         d2_h_s, d2_v_s;
  logic                take_h_s, take_v_s;

  // Angle accumulator arithmetic: frame start offset and per-column step, both wrapped mod 360 deg.
  always_comb begin
    heading_s    = {player_ang_x_i, 10'd0} + {10'd0, player_ang_y_i};
    start_diff_s = heading_s - HALF_FOV;
    step_sum_s   = {1'b0, acc_q} + ANG_STEP;
    if (start_diff_s[19]) begin
      start_acc_s = 19'(start_diff_s + ANG_MOD);
    end else begin
      start_acc_s = start_diff_s[18:0];
    end
    if (step_sum_s >= ANG_MOD) begin
      next_acc_s = 19'(step_sum_s - ANG_MOD);
    end else begin
      next_acc_s = step_sum_s[18:0];
    end
  end

  assign d2_h_s = dist2(wx_h_q, wy_h_q, px_q, py_q);
  assign d2_v_s = dist2(wx_v_q, wy_v_q, px_q, py_q);

  // Next-state and datapath update for the column sequencer.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    acc_d        = acc_q;
    px_d         = px_q;
    py_d         = py_q;
    timer_d      = timer_q;
    first_d      = first_q;
    done_h_d     = done_h_q;
    done_v_d     = done_v_q;
    found_h_d    = found_h_q;
    found_v_d    = found_v_q;
    wx_h_d       = wx_h_q;
    wy_h_d       = wy_h_q;
    wx_v_d       = wx_v_q;
    wy_v_d       = wy_v_q;
    hit_d        = hit_q;
    side_d       = side_q;
    cwx_d        = cwx_q;
    cwy_d        = cwy_q;
    cd2_d        = cd2_q;
    frame_done_d = 1'b0;
    take_h_s     = 1'b0;
    take_v_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_frame_i) begin
          state_d = S_LAUNCH;
          px_d    = player_x_i;
          py_d    = player_y_i;
          acc_d   = start_acc_s;
          col_d   = 9'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        done_h_d  = 1'b0;
        done_v_d  = 1'b0;
        found_h_d = 1'b0;
        found_v_d = 1'b0;
        timer_d   = '0;
        first_d   = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle may still see the done level left over from
        // the previous ray, so it is not sampled.
        first_d  = 1'b0;
        timer_d  = timer_q + TIMER_W'(1);
        take_h_s = !first_q && end_calc_h_i && !done_h_q;
        take_v_s = !first_q && end_calc_v_i && !done_v_q;
        if (take_h_s) begin
          done_h_d  = 1'b1;
          found_h_d = found_h_i;
          wx_h_d    = wall_x_h_i;
          wy_h_d    = wall_y_h_i;
        end else begin
          done_h_d  = done_h_q;
        end
        if (take_v_s) begin
          done_v_d  = 1'b1;
          found_v_d = found_v_i;
          wx_v_d    = wall_x_v_i;
          wy_v_d    = wall_y_v_i;
        end else begin
          done_v_d  = done_v_q;
        end
        if (done_h_d && done_v_d) begin
          state_d = S_SELECT;
        end else if (timer_q >= TIMER_LAST) begin
          // A silent side keeps found=0 from LAUNCH and counts as a miss.
          state_d  = S_SELECT;
          done_h_d = 1'b1;
          done_v_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SELECT: begin
        hit_d = 1'b1;
        if (found_h_q && found_v_q) begin
          if (d2_v_s <= d2_h_s) begin
            side_d = 1'b1;
            cwx_d  = wx_v_q;
            cwy_d  = wy_v_q;
            cd2_d  = d2_v_s;
          end else begin
            side_d = 1'b0;
            cwx_d  = wx_h_q;
            cwy_d  = wy_h_q;
            cd2_d  = d2_h_s;
          end
        end else if (found_v_q) begin
          side_d = 1'b1;
          cwx_d  = wx_v_q;
          cwy_d  = wy_v_q;
          cd2_d  = d2_v_s;
        end else if (found_h_q) begin
          side_d = 1'b0;
          cwx_d  = wx_h_q;
          cwy_d  = wy_h_q;
          cd2_d  = d2_h_s;
        end else begin
          hit_d  = 1'b0;
          side_d = 1'b0;
          cwx_d  = 13'sd0;
          cwy_d  = 13'sd0;
          cd2_d  = 27'd0;
        end
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (col_ready_i) begin
          if (col_q == COL_LAST) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          state_d = S_OUTPUT;
        end
      end
      S_NEXT: begin
        col_d   = col_q + 9'd1;
        acc_d   = next_acc_s;
        state_d = S_LAUNCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      col_q        <= 9'd0;
      acc_q        <= 19'd0;
      px_q         <= 13'sd0;
      py_q         <= 13'sd0;
      timer_q      <= '0;
      first_q      <= 1'b0;
      done_h_q     <= 1'b0;
      done_v_q     <= 1'b0;
      found_h_q    <= 1'b0;
      found_v_q    <= 1'b0;
      wx_h_q       <= 13'sd0;
      wy_h_q       <= 13'sd0;
      wx_v_q       <= 13'sd0;
      wy_v_q       <= 13'sd0;
      hit_q        <= 1'b0;
      side_q       <= 1'b0;
      cwx_q        <= 13'sd0;
      cwy_q        <= 13'sd0;
      cd2_q        <= 27'd0;
      frame_done_q <= 1'b0;
      begin_calc_q <= 1'b0;
      col_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      acc_q        <= acc_d;
      px_q         <= px_d;
      py_q         <= py_d;
      timer_q      <= timer_d;
      first_q      <= first_d;
      done_h_q     <= done_h_d;
      done_v_q     <= done_v_d;
      found_h_q    <= found_h_d;
      found_v_q    <= found_v_d;
      wx_h_q       <= wx_h_d;
      wy_h_q       <= wy_h_d;
      wx_v_q       <= wx_v_d;
      wy_v_q       <= wy_v_d;
      hit_q        <= hit_d;
      side_q       <= side_d;
      cwx_q        <= cwx_d;
      cwy_q        <= cwy_d;
      cd2_q        <= cd2_d;
      frame_done_q <= frame_done_d;
      begin_calc_q <= (state_d == S_LAUNCH);
      col_valid_q  <= (state_d == S_OUTPUT);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign alpha_x_o    = {1'b0, acc_q[18:10]};
  assign alpha_y_o    = acc_q[9:0];
  assign begin_calc_o = begin_calc_q;
  assign col_valid_o  = col_valid_q;
  assign col_index_o  = col_q;
  assign col_hit_o    = hit_q;
  assign col_side_o   = side_q;
  assign col_wall_x_o = cwx_q;
  assign col_wall_y_o = cwy_q;
  assign col_dist2_o  = cd2_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Scoreboard bench for ray_column_scheduler: a finder model answers each
// launch and pushes the expected column result; a monitor pops and compares
// it when the scheduler presents the column.
module tb_ray_column_scheduler;

  localparam int NUM_COLS   = 320;
  localparam int ANGLE_STEP = 192;
  localparam int TIMEOUT    = 4096;
  localparam int ANG_M      = 368640;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start_frame, begin_calc, col_valid, col_ready;
  logic signed [12:0] player_x, player_y;
  logic [9:0]         player_ang_x, player_ang_y, alpha_x, alpha_y;
  logic               end_h, end_v, found_h, found_v;
  logic signed [12:0] wall_x_h, wall_y_h, wall_x_v, wall_y_v;
  logic [8:0]         col_index;
  logic               col_hit, col_side, busy, frame_done;
  logic signed [12:0] col_wall_x, col_wall_y;
  logic [26:0]        col_dist2;

  ray_column_scheduler dut (
    .clk_i(clk), .reset_i(reset), .start_frame_i(start_frame),
    .player_x_i(player_x), .player_y_i(player_y),
    .player_ang_x_i(player_ang_x), .player_ang_y_i(player_ang_y),
    .alpha_x_o(alpha_x), .alpha_y_o(alpha_y), .begin_calc_o(begin_calc),
    .end_calc_h_i(end_h), .end_calc_v_i(end_v),
    .found_h_i(found_h), .found_v_i(found_v),
    .wall_x_h_i(wall_x_h), .wall_y_h_i(wall_y_h),
    .wall_x_v_i(wall_x_v), .wall_y_v_i(wall_y_v),
    .col_valid_o(col_valid), .col_ready_i(col_ready), .col_index_o(col_index),
    .col_hit_o(col_hit), .col_side_o(col_side),
    .col_wall_x_o(col_wall_x), .col_wall_y_o(col_wall_y),
    .col_dist2_o(col_dist2), .busy_o(busy), .frame_done_o(frame_done)
  );

  typedef struct {
    bit en_h; bit en_v; bit fh; bit fv;
    int wxh; int wyh; int wxv; int wyv;
    int dh; int dv;
  } cfg_t;

  typedef struct {
    int idx; bit hit; bit side; int wx; int wy; longint d2;
    longint a; bit tmo; longint t_launch;
  } exp_t;

  exp_t   sb[$];
  int     chk_cnt = 0;
  int     err_cnt = 0;
  int     mode = 0, frame_id = 0, launch_cnt = 0, start_acc = 0, hold_col = -1;
  bit     hold_done = 1'b0;
  int     ppx = 0, ppy = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    chk_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint d2m(input int wx, input int wy, input int px, input int py);
    longint dx, dy;
    dx = longint'(wx) - longint'(px);
    dy = longint'(wy) - longint'(py);
    return dx * dx + dy * dy;
  endfunction

  // Finder behaviour for column c of frame f in stimulus mode m.
  function automatic cfg_t get_cfg(input int m, input int f, input int c);
    cfg_t r;
    r.en_h = 1'b1; r.en_v = 1'b1;
    r.fh  = (c % 4 == 0) || (c % 4 == 2);
    r.fv  = (c % 4 == 0) || (c % 4 == 1);
    r.wxh = ((c * 37 + f * 11) % 4000) - 2000;
    r.wyh = ((c * 53) % 3000) - 1500;
    r.wxv = ((c * 71) % 4000) - 2000;
    r.wyv = ((c * 29 + f * 7) % 3000) - 1500;
    r.dh  = 3 + c % 5;
    r.dv  = 3 + (c * 3) % 7;
    if (c % 8 == 4) begin r.wxv = r.wyh; r.wyv = r.wxh; end
    if (f == 0 && c == 0) begin r.wxh = 100; r.wyh = 0; r.wxv = 0; r.wyv = 50; end
    if (f == 1 && c == 8) begin r.wxh = -4096; r.wyh = 4095; r.fv = 1'b0; end
    if (m == 2) begin
      r.en_v = 1'b0; r.en_h = (c == 0); r.fh = 1'b1;
      r.wxh = 30; r.wyh = 40; r.dh = 3;
    end
    return r;
  endfunction

  // Finder model: answers each launch, keeping the old done level through the first WAIT cycle.
  initial begin : finder
    cfg_t   cur;
    exp_t   e;
    int     cnt;
    bit     active, hok, vok;
    longint a_exp, dh2, dv2;
    active = 1'b0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (begin_calc) begin
        cur = get_cfg(mode, frame_id, launch_cnt);
        cnt = 0; active = 1'b1;
        a_exp = (longint'(start_acc) + longint'(launch_cnt) * ANGLE_STEP) % ANG_M;
        chk_eq("alpha_x", alpha_x, a_exp / 1024);
        chk_eq("alpha_y", alpha_y, a_exp % 1024);
        if (frame_id == 0 && launch_cnt == 107) begin
          chk_eq("alpha_wrap_x", alpha_x, 0);
          chk_eq("alpha_wrap_y", alpha_y, 64);
        end
        hok = cur.en_h && cur.fh;
        vok = cur.en_v && cur.fv;
        dh2 = d2m(cur.wxh, cur.wyh, ppx, ppy);
        dv2 = d2m(cur.wxv, cur.wyv, ppx, ppy);
        e.idx = launch_cnt; e.a = a_exp; e.tmo = !(cur.en_h && cur.en_v); e.t_launch = cyc;
        e.hit = hok || vok;
        if (vok && (!hok || dv2 <= dh2)) begin
          e.side = 1'b1; e.wx = cur.wxv; e.wy = cur.wyv; e.d2 = dv2;
        end else if (hok) begin
          e.side = 1'b0; e.wx = cur.wxh; e.wy = cur.wyh; e.d2 = dh2;
        end else begin
          e.side = 1'b0; e.wx = 0; e.wy = 0; e.d2 = 0;
        end
        sb.push_back(e);
        launch_cnt++;
      end else if (active) begin
        cnt++;
        if (cnt == 2) begin end_h = 1'b0; end_v = 1'b0; end
        if (cur.en_h && cnt == cur.dh) begin
          end_h = 1'b1; found_h = cur.fh; wall_x_h = 13'(cur.wxh); wall_y_h = 13'(cur.wyh);
        end
        if (cur.en_v && cnt == cur.dv) begin
          end_v = 1'b1; found_v = cur.fv; wall_x_v = 13'(cur.wxv); wall_y_v = 13'(cur.wyv);
        end
      end
    end
  end

  // Monitor: compares presented columns against the scoreboard, optionally stalling one.
  initial begin : monitor
    exp_t        e;
    logic [63:0] snap, now;
    int          n;
    bit          held;
    forever begin
      @(negedge clk);
      if (col_valid) begin
        held = 1'b0;
        if (int'(col_index) == hold_col && !hold_done) begin
          hold_done = 1'b1; held = 1'b1;
          col_ready = 1'b0;
          snap = {col_index, col_hit, col_side, col_wall_x, col_wall_y, col_dist2};
          for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            now = {col_index, col_hit, col_side, col_wall_x, col_wall_y, col_dist2};
            chk_eq("hold_stable", now, snap);
            chk_eq("hold_valid", col_valid, 1);
            chk_eq("hold_no_launch", begin_calc, 0);
          end
          col_ready = 1'b1;
        end
        if (sb.size() == 0) begin
          chk_eq("sb_entries", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk_eq("col_index", col_index, e.idx);
          chk_eq("col_hit", col_hit, e.hit);
          chk_eq("col_side", col_side, e.side);
          chk_eq("col_wall_x", col_wall_x, e.wx);
          chk_eq("col_wall_y", col_wall_y, e.wy);
          chk_eq("col_dist2", col_dist2, e.d2);
          chk_eq("alpha_hold", {alpha_x, alpha_y}, ((e.a / 1024) << 10) | (e.a % 1024));
          if (e.tmo)
            chk_eq("tmo_latency", (cyc - e.t_launch >= TIMEOUT) && (cyc - e.t_launch <= TIMEOUT + 4), 1);
        end
        if (held) begin
          n = 0;
          do begin @(negedge clk); n++; end while (!begin_calc && n < 4);
          chk_eq("relaunch_cycles", n, 2);
        end
      end
    end
  end

  task automatic start_frame_t(input int hx, input int hy, input int px, input int py);
    @(negedge clk);
    player_ang_x = 10'(hx); player_ang_y = 10'(hy);
    player_x = 13'(px); player_y = 13'(py);
    ppx = px; ppy = py;
    start_acc  = ((hx * 1024 + hy - 30720) + ANG_M) % ANG_M;
    launch_cnt = 0;
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    chk_eq("busy_start", busy, 1);
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (!frame_done && n < 20000) begin @(negedge clk); n++; end
    chk_eq("frame_done_seen", frame_done, 1);
    chk_eq("busy_after_frame", busy, 0);
    chk_eq("launches", launch_cnt, NUM_COLS);
    chk_eq("sb_drained", sb.size(), 0);
    @(negedge clk);
    chk_eq("frame_done_pulse", frame_done, 0);
  endtask

  initial begin : main
    int n, launches;
    reset = 1'b1; start_frame = 1'b0; col_ready = 1'b1;
    player_x = '0; player_y = '0; player_ang_x = '0; player_ang_y = '0;
    end_h = 1'b0; end_v = 1'b0; found_h = 1'b0; found_v = 1'b0;
    wall_x_h = '0; wall_y_h = '0; wall_x_v = '0; wall_y_v = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("rst_begin_calc", begin_calc, 0);
    chk_eq("rst_col_valid", col_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_frame_done", frame_done, 0);
    chk_eq("rst_alpha", {alpha_x, alpha_y}, 0);
    chk_eq("rst_col_index", col_index, 0);
    chk_eq("rst_col_hit", {col_hit, col_side}, 0);
    chk_eq("rst_col_wall", {col_wall_x, col_wall_y}, 0);
    chk_eq("rst_col_dist2", col_dist2, 0);

    // Frame A: heading 10.0 deg, player at origin, stall on column 5, stray start mid-frame.
    frame_id = 0; mode = 0; hold_col = 5; hold_done = 1'b0;
    start_frame_t(10, 0, 0, 0);
    repeat (300) @(negedge clk);
    player_ang_x = 10'd200; player_x = 13'sd999; player_y = -13'sd999;
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    wait_frame_done();

    // Frame B: heading 0.5 deg (negative start wraps), far corner player.
    frame_id = 1; hold_col = -1;
    start_frame_t(0, 512, 4095, -4096);
    wait_frame_done();

    // Frame C: timeout behaviour, then reset in the middle of a WAIT.
    frame_id = 2; mode = 2;
    start_frame_t(45, 0, 10, -20);
    n = 0;
    while (launch_cnt < 3 && n < 20000) begin @(negedge clk); n++; end
    chk_eq("third_launch_seen", launch_cnt, 3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_col_valid", col_valid, 0);
    launches = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (begin_calc) launches++;
    end
    chk_eq("midrst_no_launch", launches, 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
